first_nios2_system_sysid_checker: RTL and testbench
===================================================

Name: first_nios2_system_sysid_checker

Overview:
- Avalon-MM master that reads the system ID peripheral's control slave and checks the result against build-time expected values.
- Reads word 0 (system ID) then word 1 (timestamp), compares each against parameters, and reports pass/fail/timeout.
- Sits beside the Nios II system as a hardware self-check at boot or on demand.
- Honours avm_waitrequest and has a bounded per-read timeout.

Parameters:
- EXPECTED_ID, 32'd7: value required at word address 0.
- EXPECTED_TIMESTAMP, 32'd1381349107: value required at word address 1.
- TIMEOUT_CYCLES, 16'd255: number of consecutive waitrequest-high cycles that aborts a read. 0 disables the timeout.

Ports:
- clock  in  1  single system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request a check sequence; sampled only in IDLE.
- avm_address  out  1  word address (0 = ID, 1 = timestamp).
- avm_read  out  1  Avalon read strobe.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  slave read data; valid when avm_read=1 and avm_waitrequest=0.
- busy  out  1  high while a sequence is in progress (RD_ID, RD_TS).
- done  out  1  one-cycle pulse at the end of a sequence.
- pass  out  1  both words matched, no timeout.
- timeout  out  1  a read was aborted by timeout.
- id_value  out  32  captured word 0.
- ts_value  out  32  captured word 1.

Behaviour:
- Reset:
  - reset_n=0 at a rising edge forces state=IDLE.
  - All outputs are driven to 0 (avm_read, avm_address, busy, done, pass, timeout, id_value, ts_value); the wait counter is cleared.
  - Reset mid-read: avm_read is 0 from the next edge. No capture occurs. done is not pulsed.
- FSM states: IDLE, RD_ID, RD_TS, DONE.
- IDLE:
  - avm_read=0, busy=0.
  - start=1 → RD_ID. On that edge: pass, timeout, id_value and ts_value are cleared to 0, and the wait counter is cleared.
- RD_ID:
  - avm_read=1, avm_address=0, busy=1.
  - avm_waitrequest=0 → capture avm_readdata into id_value, clear the wait counter, go to RD_TS.
  - avm_waitrequest=1 → increment the wait counter. The address stays stable and the read stays asserted.
- RD_TS:
  - Same rules as RD_ID with avm_address=1.
  - On acceptance: capture into ts_value, go to DONE.
- Timeout:
  - Applies in RD_ID and RD_TS when TIMEOUT_CYCLES≠0.
  - When waitrequest=1 and wait counter == TIMEOUT_CYCLES-1, the sequence aborts on that edge: go to DONE, set timeout=1, set pass=0, and drop avm_read.
  - The next cycle's readdata is ignored.
  - The second read is never issued after an ID-read timeout.
- DONE:
  - done=1 for exactly this cycle; busy=0, avm_read=0.
  - pass = (id_value==EXPECTED_ID) && (ts_value==EXPECTED_TIMESTAMP) && !timeout, registered on entry to DONE so it is valid while done=1.
  - Next state is always IDLE.
- Result hold: pass, timeout, id_value and ts_value hold until the next accepted start.
- Ignored start: start during RD_ID, RD_TS or DONE is ignored (not queued).
- Latency: with zero wait states, start sampled at edge N gives:
  - avm_read high in cycles N+1 and N+2;
  - done high in cycle N+3;
  - busy high for exactly 2 cycles.
- Wait states: each waitrequest-high cycle extends the sequence by one cycle.
- Wait counter: 16 bits, saturating; it never wraps.
- Mismatch is not an error stop: both reads are always completed unless a timeout occurs.

Test Plan:
- Reset, then start=1 for 1 cycle, slave returns 7 then 1381349107 with no wait states → avm_read high 2 cycles (addr 0 then 1), done pulse in cycle N+3, pass=1, timeout=0, id_value=7, ts_value=1381349107.
- Slave returns 8 for ID and the correct timestamp → both reads issued, done pulse, pass=0, id_value=8.
- waitrequest held high 3 cycles on each read → busy high 8 cycles, addresses stable during stalls, pass=1.
- TIMEOUT_CYCLES=4 with waitrequest stuck high on the ID read → avm_read high exactly 4 cycles at addr 0 then drops, address 1 never issued, done pulse, timeout=1, pass=0.
- reset_n=0 for 1 cycle while in RD_TS with waitrequest high → next cycle all outputs 0, no done pulse; a following start runs a clean sequence with pass=1.
- start held high continuously → sequences back-to-back with one IDLE cycle between each DONE and the next RD_ID; results cleared at each new start.

Source files
------------

// File: rtl/first_nios2_system_sysid_checker.sv
// Boot-time self-check: reads the sysid slave (ID word, then timestamp word) over
// Avalon-MM and reports whether both match the values this build was generated with.
module first_nios2_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd7,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1381349107,
    parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RD_ID = 2'd1;
    localparam logic [1:0] RD_TS = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state;
    logic [15:0] wait_count;
    logic        timeout_hit;

    // The abort fires on the stalled cycle that would be the TIMEOUT_CYCLES-th in a row.
    assign timeout_hit = (TIMEOUT_CYCLES != 16'd0) && avm_waitrequest &&
                         (wait_count == TIMEOUT_CYCLES - 16'd1);

    assign avm_read    = (state == RD_ID) || (state == RD_TS);
    assign avm_address = (state == RD_TS);
    assign busy        = (state == RD_ID) || (state == RD_TS);
    assign done        = (state == DONE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            wait_count <= 16'd0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            id_value   <= 32'd0;
            ts_value   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RD_ID;
                        wait_count <= 16'd0;
                        pass       <= 1'b0;
                        timeout    <= 1'b0;
                        id_value   <= 32'd0;
                        ts_value   <= 32'd0;
                    end
                end
                RD_ID, RD_TS: begin
                    if (!avm_waitrequest) begin
                        wait_count <= 16'd0;
                        if (state == RD_ID) begin
                            id_value <= avm_readdata;
                            state    <= RD_TS;
                        end else begin
                            ts_value <= avm_readdata;
                            // Compare against the incoming word so pass is valid during done.
                            pass     <= (id_value == EXPECTED_ID) &&
                                        (avm_readdata == EXPECTED_TIMESTAMP) && !timeout;
                            state    <= DONE;
                        end
                    end else if (timeout_hit) begin
                        wait_count <= 16'd0;
                        timeout    <= 1'b1;
                        pass       <= 1'b0;
                        state      <= DONE;
                    end else if (wait_count != 16'hFFFF) begin
                        wait_count <= wait_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Randomized check of the sysid checker against a per-transaction reference model
// that plans each sequence's waveform from wait-state counts and returned data.
module tb_first_nios2_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd7;
    localparam logic [31:0] EXP_TS = 32'd1381349107;
    localparam logic [15:0] TO     = 16'd4;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    logic        expRead, expAddr, expBusy, expDone, expPass, expTimeout;
    logic [31:0] expId, expTs;
    bit          checkEn;
    int          checks, errors;
    int          busyCycles, doneCycles, readCycles, addr1Cycles;

    first_nios2_system_sysid_checker #(
        .EXPECTED_ID(EXP_ID),
        .EXPECTED_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata(avm_readdata),
        .busy(busy),
        .done(done),
        .pass(pass),
        .timeout(timeout),
        .id_value(id_value),
        .ts_value(ts_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("avm_read", {31'd0, avm_read}, {31'd0, expRead});
        checkOutput("avm_address", {31'd0, avm_address}, {31'd0, expAddr});
        checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
        checkOutput("done", {31'd0, done}, {31'd0, expDone});
        checkOutput("pass", {31'd0, pass}, {31'd0, expPass});
        checkOutput("timeout", {31'd0, timeout}, {31'd0, expTimeout});
        checkOutput("id_value", id_value, expId);
        checkOutput("ts_value", ts_value, expTs);
        if (busy === 1'b1) busyCycles++;
        if (done === 1'b1) doneCycles++;
        if (avm_read === 1'b1) readCycles++;
        if (avm_read === 1'b1 && avm_address === 1'b1) addr1Cycles++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic setBus(input logic r, input logic a, input logic b, input logic d);
        expRead = r;
        expAddr = a;
        expBusy = b;
        expDone = d;
    endtask

    // One check sequence: w0/w1 stalled cycles before each read is accepted; a stall
    // count reaching TO aborts. rstAt >= 0 pulses reset on that stall of the timestamp read.
    task automatic applyStimulus(input int w0, input int w1, input logic [31:0] idData,
                                 input logic [31:0] tsData, input bit holdStart, input int rstAt);
        bit timedOut;
        bit aborted;
        int w;
        timedOut = 1'b0;
        aborted  = 1'b0;
        start = 1'b1;
        step();
        start = holdStart ? 1'b1 : 1'($urandom_range(0, 1));
        expPass = 1'b0; expTimeout = 1'b0; expId = 32'd0; expTs = 32'd0;
        for (int p = 0; p < 2; p++) begin
            if (timedOut || aborted) break;
            w = (p == 0) ? w0 : w1;
            for (int i = 0; ; i++) begin
                setBus(1'b1, (p == 1), 1'b1, 1'b0);
                if (!holdStart) start = 1'($urandom_range(0, 1));
                if (i < w) begin
                    avm_waitrequest = 1'b1;
                    avm_readdata = $urandom;
                    if (p == 1 && i == rstAt) begin
                        reset_n = 1'b0;
                        step();
                        reset_n = 1'b1;
                        start = 1'b0;
                        aborted = 1'b1;
                        setBus(1'b0, 1'b0, 1'b0, 1'b0);
                        expPass = 1'b0; expTimeout = 1'b0; expId = 32'd0; expTs = 32'd0;
                        step();
                        break;
                    end
                    if (i == int'(TO) - 1) begin
                        step();
                        timedOut = 1'b1;
                        break;
                    end
                    step();
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata = (p == 0) ? idData : tsData;
                    step();
                    if (p == 0) expId = idData;
                    else expTs = tsData;
                    break;
                end
            end
        end
        if (aborted) return;
        setBus(1'b0, 1'b0, 1'b0, 1'b1);
        expTimeout = timedOut;
        expPass = !timedOut && (idData == EXP_ID) && (tsData == EXP_TS);
        avm_waitrequest = 1'($urandom_range(0, 1));
        avm_readdata = $urandom;
        if (!holdStart) start = 1'($urandom_range(0, 1));
        step();
        setBus(1'b0, 1'b0, 1'b0, 1'b0);
        start = holdStart;
        avm_waitrequest = 1'($urandom_range(0, 1));
        avm_readdata = $urandom;
    endtask

    initial begin
        int b0, d0, r0, a0;
        int w0, w1;
        logic [31:0] idData, tsData;
        checks = 0; errors = 0;
        busyCycles = 0; doneCycles = 0; readCycles = 0; addr1Cycles = 0;
        checkEn = 1'b0;
        fork
            forever begin
                @(negedge clock);
                if (checkEn) compareAll();
            end
        join_none

        reset_n = 1'b0; start = 1'b0; avm_waitrequest = 1'b0; avm_readdata = 32'd0;
        setBus(1'b0, 1'b0, 1'b0, 1'b0);
        expPass = 1'b0; expTimeout = 1'b0; expId = 32'd0; expTs = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        checkEn = 1'b1;
        step();
        reset_n = 1'b1;
        step();

        // Nominal zero-wait sequence, pinned by literals.
        b0 = busyCycles; d0 = doneCycles; r0 = readCycles;
        applyStimulus(0, 0, 32'd7, 32'd1381349107, 1'b0, -1);
        checkOutput("lit_busy_len", busyCycles - b0, 32'd2);
        checkOutput("lit_done_len", doneCycles - d0, 32'd1);
        checkOutput("lit_read_len", readCycles - r0, 32'd2);
        checkOutput("lit_pass", {31'd0, pass}, 32'd1);
        checkOutput("lit_id", id_value, 32'd7);
        checkOutput("lit_ts", ts_value, 32'd1381349107);

        // Wrong ID: both reads still complete.
        r0 = readCycles;
        applyStimulus(0, 0, 32'd8, EXP_TS, 1'b0, -1);
        checkOutput("lit_mismatch_reads", readCycles - r0, 32'd2);
        checkOutput("lit_mismatch_pass", {31'd0, pass}, 32'd0);
        checkOutput("lit_mismatch_id", id_value, 32'd8);

        // Three stalls on each read.
        b0 = busyCycles;
        applyStimulus(3, 3, EXP_ID, EXP_TS, 1'b0, -1);
        checkOutput("lit_stall_busy", busyCycles - b0, 32'd8);
        checkOutput("lit_stall_pass", {31'd0, pass}, 32'd1);

        // Waitrequest stuck on the ID read.
        r0 = readCycles; a0 = addr1Cycles;
        applyStimulus(50, 0, EXP_ID, EXP_TS, 1'b0, -1);
        checkOutput("lit_to_reads", readCycles - r0, 32'd4);
        checkOutput("lit_to_addr1", addr1Cycles - a0, 32'd0);
        checkOutput("lit_to_flag", {31'd0, timeout}, 32'd1);
        checkOutput("lit_to_pass", {31'd0, pass}, 32'd0);

        // Reset while stalled on the timestamp read, then a clean run.
        d0 = doneCycles;
        applyStimulus(0, 3, EXP_ID, EXP_TS, 1'b0, 1);
        checkOutput("lit_rst_nodone", doneCycles - d0, 32'd0);
        applyStimulus(0, 0, EXP_ID, EXP_TS, 1'b0, -1);
        checkOutput("lit_rst_recover", {31'd0, pass}, 32'd1);

        // start held high: back-to-back sequences.
        applyStimulus(1, 0, EXP_ID, 32'h1234_5678, 1'b1, -1);
        applyStimulus(0, 2, EXP_ID, EXP_TS, 1'b1, -1);
        applyStimulus(0, 9, 32'hDEAD_BEEF, EXP_TS, 1'b1, -1);
        applyStimulus(2, 1, EXP_ID, EXP_TS, 1'b0, -1);

        // Randomized sequences.
        for (int n = 0; n < 40; n++) begin
            w0 = $urandom_range(0, 5);
            w1 = $urandom_range(0, 5);
            idData = ($urandom_range(0, 2) != 0) ? EXP_ID : $urandom;
            tsData = ($urandom_range(0, 2) != 0) ? EXP_TS : $urandom;
            applyStimulus(w0, w1, idData, tsData, 1'($urandom_range(0, 1)), -1);
        end
        start = 1'b0;
        step();
        step();
        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
